add_subb_serial: RTL

ADD_SUBB_SERIAL -- requirements
Module: add_subb_serial

---
 rtl/add_subb_serial_pkg.sv | 23 ++
 rtl/add_subb_digit.sv | 18 +
 rtl/add_subb_serial_defs.vh | 11 +
 rtl/add_subb_serial.sv | 129 ++++++++++++
 4 files changed

// File: rtl/add_subb_serial_pkg.sv
// Shared FSM type and overflow helper for the digit-serial add/subtract unit.
`include "add_subb_serial_defs.vh"

package add_subb_serial_pkg;

   typedef enum logic [1:0] {
      IDLE = `ADD_SUBB_ST_IDLE,
      RUN  = `ADD_SUBB_ST_RUN,
      DONE = `ADD_SUBB_ST_DONE
   } state_t;

   // Bits W+1..W of the exact sum come from the sign-extended operands plus the
   // final carry; the result fits W bits only if they match the result sign.
   function automatic logic signed_ovf(input logic       x_msb,
                                       input logic       y_msb,
                                       input logic       s_msb,
                                       input logic [1:0] carry);
      logic [1:0] hi;
      hi = {2{x_msb}} + {2{y_msb}} + carry;
      return hi != {2{s_msb}};
   endfunction

endpackage

// File: rtl/add_subb_digit.sv
// Combinational D-bit digit adder; the 2-bit carry covers both injected negation carries.
module add_subb_digit #(
   parameter int D = 4
) (
   input  logic [D-1:0] x,
   input  logic [D-1:0] y,
   input  logic [1:0]   cin,
   output logic [D-1:0] sum,
   output logic [1:0]   cout
);

   logic [D+1:0] total;

   assign total = {2'b00, x} + {2'b00, y} + {{D{1'b0}}, cin};
   assign sum   = total[D-1:0];
   assign cout  = total[D+1:D];

endmodule

// File: rtl/add_subb_serial_defs.vh
// State encodings and digit-count derivation shared by the serial add/subtract unit.
`ifndef ADD_SUBB_SERIAL_DEFS_VH
`define ADD_SUBB_SERIAL_DEFS_VH

`define ADD_SUBB_ST_IDLE 2'd0
`define ADD_SUBB_ST_RUN  2'd1
`define ADD_SUBB_ST_DONE 2'd2

`define ADD_SUBB_N(w, d) ((w) / (d))

`endif

// File: rtl/add_subb_serial.sv
// Digit-serial signed add/subtract: (+/-a) + (+/-b), D bits per enabled cycle, LSB digit first.
`include "add_subb_serial_defs.vh"

module add_subb_serial
   import add_subb_serial_pkg::*;
#(
   parameter int W = 16,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         subb_a,
   input  logic         subb_b,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] s,
   output logic         ovf
);

   localparam int N     = `ADD_SUBB_N(W, D);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int NP    = 1 << CNT_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [1:0]       carry_reg;
   logic [W-1:0]     a_reg, b_reg, acc_reg, s_reg;
   logic             sa_reg, sb_reg, ovf_reg;

   logic [D-1:0]     a_dig [NP];
   logic [D-1:0]     b_dig [NP];
   logic [D-1:0]     x_dig, y_dig, sum_dig;
   logic [1:0]       cout_dig;
   logic [W-1:0]     acc_full;
   logic             last_dig, in_fire, out_fire;

   // Digit table padded to a power of two so the counter can index it directly.
   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_dig
         if (gi < N) begin : g_live
            assign a_dig[gi] = a_reg[gi*D +: D];
            assign b_dig[gi] = b_reg[gi*D +: D];
            assign acc_full[gi*D +: D] =
               (cnt_reg == CNT_W'(gi)) ? sum_dig : acc_reg[gi*D +: D];
         end else begin : g_pad
            assign a_dig[gi] = '0;
            assign b_dig[gi] = '0;
         end
      end
   endgenerate

   assign x_dig    = a_dig[cnt_reg] ^ {D{sa_reg}};
   assign y_dig    = b_dig[cnt_reg] ^ {D{sb_reg}};
   assign last_dig = (cnt_reg == LAST);

   add_subb_digit #(.D(D)) u_digit (
      .x    (x_dig),
      .y    (y_dig),
      .cin  (carry_reg),
      .sum  (sum_dig),
      .cout (cout_dig)
   );

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      if (ena) begin
         in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
         out_valid = (state_reg == DONE);
      end
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      case (state_reg)
         IDLE:    if (in_fire) state_next = RUN;
         RUN:     if (ena && last_dig) state_next = DONE;
         DONE:    if (out_fire) state_next = in_fire ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         carry_reg <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         acc_reg   <= '0;
         sa_reg    <= 1'b0;
         sb_reg    <= 1'b0;
         s_reg     <= '0;
         ovf_reg   <= 1'b0;
      end else if (ena) begin
         state_reg <= state_next;
         if (in_fire) begin
            a_reg     <= a;
            b_reg     <= b;
            sa_reg    <= subb_a;
            sb_reg    <= subb_b;
            cnt_reg   <= '0;
            // Negation = inversion here plus +1 injected per negated operand.
            carry_reg <= {1'b0, subb_a} + {1'b0, subb_b};
         end else if (state_reg == RUN) begin
            acc_reg <= acc_full;
            if (last_dig) begin
               cnt_reg   <= '0;
               carry_reg <= '0;
               s_reg     <= acc_full;
               ovf_reg   <= signed_ovf(x_dig[D-1], y_dig[D-1], sum_dig[D-1], cout_dig);
            end else begin
               cnt_reg   <= cnt_reg + CNT_W'(1);
               carry_reg <= cout_dig;
            end
         end
      end
   end

   assign s   = s_reg;
   assign ovf = ovf_reg;

endmodule
